line_burst_adapter: RTL and testbench
=====================================

Name: line_burst_adapter

Overview:
- Memory-side responder for the line-granular cache interface: pmem_read/pmem_write, pmem_address, LINE_SIZE-bit data, one-cycle pmem_resp.
- Converts each line request into a fixed-length burst on a narrower burst-memory bus: BEATS = LINE_SIZE/BURST_WIDTH beats.
- Sits between the cache (or the cache arbiter) and the burst DRAM model or controller.
- Serves one outstanding transaction at a time.

Parameters:
- LINE_SIZE, 256, cache line width in bits.
- BURST_WIDTH, 64, burst bus data width in bits. Must divide LINE_SIZE.
- BEATS (localparam) = LINE_SIZE/BURST_WIDTH, default 4. Beat counter width is $clog2(BEATS).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pmem_address  in  32  line address from cache. Bits [$clog2(LINE_SIZE/8)-1:0] are ignored and forced to 0 on output.
- pmem_read  in  1  line read request, held until pmem_resp.
- pmem_write  in  1  line write request, held until pmem_resp.
- pmem_wdata  in  LINE_SIZE  write line. Valid while pmem_write is high.
- pmem_rdata  out  LINE_SIZE  assembled read line.
- pmem_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  line-aligned burst address.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  burst write command / write beat valid.
- bmem_wdata  out  BURST_WIDTH  write beat data.
- bmem_ready  in  1  memory accepts a command or write beat this cycle.
- bmem_rdata  in  BURST_WIDTH  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, beat counter=0.
  - Outputs: pmem_resp=0, pmem_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
  - A reset mid-burst abandons the transaction. Partial line data is discarded and no pmem_resp is issued.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - Request sampled in IDLE only.
  - pmem_write has priority over pmem_read when both are high (writeback before fill).
  - On write: latch the aligned address and pmem_wdata into the line buffer, go to WR_DATA.
  - On read: latch the aligned address, go to RD_CMD.
- RD_CMD:
  - Drive bmem_read=1 and bmem_addr.
  - On a cycle with bmem_ready=1, deassert bmem_read next cycle, clear the counter, go to RD_DATA.
- RD_DATA:
  - Each cycle with bmem_rvalid=1, store bmem_rdata in slice [cnt*BURST_WIDTH +: BURST_WIDTH]. Beat 0 is the least-significant slice.
  - Increment the counter.
  - On beat BEATS-1, the full line is written to pmem_rdata; go to RESP.
  - rvalid gaps are allowed.
- WR_DATA:
  - Drive bmem_write=1, bmem_addr, and bmem_wdata = slice cnt of the line buffer.
  - Advance the counter only on cycles with bmem_ready=1. Data and addr are held stable while ready=0.
  - After beat BEATS-1 is accepted, drop bmem_write and go to RESP.
- RESP:
  - pmem_resp=1 for exactly one cycle, then IDLE.
  - The cache deasserts its request on the same edge, so no request is re-sampled.
- pmem_rdata holds its value until the next read completes. Writes do not modify it.
- Latency:
  - Read: 1 (accept) + cmd wait + BEATS rvalid cycles + 1 (RESP).
  - Write: 1 + BEATS accepted cycles + 1. Minimum is 6 cycles with BEATS=4 and no stalls.
- bmem_rvalid is ignored outside RD_DATA. Stray beats are dropped.
- The counter wraps to 0 on final-beat completion.
- All outputs are registered.

Optional Feature:
- Macro LINE_BURST_ADAPTER_PERF_EN.
- When defined: internal 64-bit counters rd_lines, wr_lines and stall_cycles are kept. stall_cycles counts cycles with bmem_ready=0 in RD_CMD or WR_DATA, plus cycles with bmem_rvalid=0 in RD_DATA. All counters clear on reset and are readable hierarchically by the bench.
- When undefined: no counters, no added logic. Ports are identical in both builds.

Decomposition:
- Package rv32i_types gains:
  - adapter_state_t enum {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP}.
  - Constants LINE_BYTES_SHIFT = $clog2(LINE_SIZE/8) and DEFAULT_BURST_WIDTH = 64.
- No sub-module required. FSM, beat counter and line buffer stay in one file.
- A beat-slice mux may be a function in the package.

Test Plan:
- Read, no stalls: pmem_read=1, pmem_address=0x1234_5678. ready=1; rvalid beats 0x11..11, 0x22..22, 0x33..33, 0x44..44. Expect:
  - bmem_addr=0x1234_5660.
  - pmem_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
  - pmem_resp high exactly one cycle, 6 cycles after the request.
- Write with stalls: pmem_write=1, pmem_wdata=beats {D3,D2,D1,D0}, ready toggling 0/1. Expect:
  - Beats emitted D0, D1, D2, D3.
  - Each beat held stable while ready=0.
  - Exactly 4 accepted beats, then one pmem_resp.
- Simultaneous read and write in IDLE: expect the write burst first and one pmem_resp. The read is then serviced after the cache re-presents it.
- rvalid gaps: beats with 2-cycle gaps. Expect the correct line and no extra resp. A stray rvalid in IDLE leaves pmem_rdata unchanged.
- Reset mid-burst: assert rst low after beat 2 of a read. Expect:
  - All outputs 0 immediately (asynchronous).
  - No pmem_resp.
  - A subsequent read completes normally.
- PERF_EN build: run the write-with-stalls case. Expect wr_lines=1 and stall_cycles equal to the number of ready=0 cycles.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the memory-side line/burst adapter.
package rv32i_types;

  localparam int unsigned DEFAULT_LINE_SIZE   = 256;
  localparam int unsigned DEFAULT_BURST_WIDTH = 64;
  localparam int unsigned LINE_BYTES_SHIFT    = $clog2(DEFAULT_LINE_SIZE / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_DATA,
    RESP
  } adapter_state_t;

endpackage

// File: rtl/line_burst_adapter.sv
// Turns one line-granular read/write into a BEATS-long burst on a narrow bus.
// Optional perf counters: define LINE_BURST_ADAPTER_PERF_EN.
module line_burst_adapter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_SIZE   = DEFAULT_LINE_SIZE,
  parameter int unsigned BURST_WIDTH = DEFAULT_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pmem_address,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [LINE_SIZE-1:0]   pmem_wdata,
  output logic [LINE_SIZE-1:0]   pmem_rdata,
  output logic                   pmem_resp,
  output logic [31:0]            bmem_addr,
  output logic                   bmem_read,
  output logic                   bmem_write,
  output logic [BURST_WIDTH-1:0] bmem_wdata,
  input  logic                   bmem_ready,
  input  logic [BURST_WIDTH-1:0] bmem_rdata,
  input  logic                   bmem_rvalid
);

  localparam int unsigned BEATS      = LINE_SIZE / BURST_WIDTH;
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ADDR_SHIFT = $clog2(LINE_SIZE / 8);
  localparam logic [31:0] ADDR_MASK  = ~((32'd1 << ADDR_SHIFT) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adapter_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [LINE_SIZE-1:0]   line_q, line_d, line_fill;
  logic [LINE_SIZE-1:0]   rdata_q, rdata_d;
  logic                   resp_q, resp_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic [31:0]            addr_q, addr_d;
  logic [BURST_WIDTH-1:0] wdata_q, wdata_d;

  assign cnt_inc    = cnt_q + 1'b1;
  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = read_q;
  assign bmem_write = write_q;
  assign bmem_wdata = wdata_q;

  always_comb begin
    line_fill = line_q;
    line_fill[int'(cnt_q) * BURST_WIDTH +: BURST_WIDTH] = bmem_rdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // Write wins so a dirty victim is flushed before its replacement fill.
        if (pmem_write) begin
          state_d = WR_DATA;
          addr_d  = pmem_address & ADDR_MASK;
          line_d  = pmem_wdata;
          write_d = 1'b1;
          wdata_d = pmem_wdata[BURST_WIDTH-1:0];
          cnt_d   = '0;
        end else if (pmem_read) begin
          state_d = RD_CMD;
          addr_d  = pmem_address & ADDR_MASK;
          read_d  = 1'b1;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          read_d  = 1'b0;
          cnt_d   = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid) begin
          line_d = line_fill;
          if (cnt_q == LAST_BEAT) begin
            rdata_d = line_fill;
            cnt_d   = '0;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WR_DATA: begin
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            write_d = 1'b0;
            cnt_d   = '0;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = cnt_inc;
            wdata_d = line_q[int'(cnt_inc) * BURST_WIDTH +: BURST_WIDTH];
          end
        end
      end
      RESP: begin
        resp_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef LINE_BURST_ADAPTER_PERF_EN
  logic [63:0] rd_lines;
  logic [63:0] wr_lines;
  logic [63:0] stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lines     <= '0;
      wr_lines     <= '0;
      stall_cycles <= '0;
    end else begin
      if (state_q == RD_DATA && bmem_rvalid && cnt_q == LAST_BEAT) begin
        rd_lines <= rd_lines + 64'd1;
      end
      if (state_q == WR_DATA && bmem_ready && cnt_q == LAST_BEAT) begin
        wr_lines <= wr_lines + 64'd1;
      end
      if (((state_q == RD_CMD || state_q == WR_DATA) && !bmem_ready) ||
          (state_q == RD_DATA && !bmem_rvalid)) begin
        stall_cycles <= stall_cycles + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: reads, stalled writes, priority, gaps, async reset.
module tb_line_burst_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks;
  int errors;

  logic [255:0] wline1, wline2, rline1, rline2, rline3, rline4;

  line_burst_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .bmem_addr    (bmem_addr),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_ready   (bmem_ready),
    .bmem_rdata   (bmem_rdata),
    .bmem_rvalid  (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp"},   pmem_resp,  0);
    chk({tag, "_rdata"},  pmem_rdata, 0);
    chk({tag, "_bread"},  bmem_read,  0);
    chk({tag, "_bwrite"}, bmem_write, 0);
    chk({tag, "_baddr"},  bmem_addr,  0);
    chk({tag, "_bwdata"}, bmem_wdata, 0);
  endtask

  // Drives a full read burst; a junk beat is offered during the command cycle.
  task automatic rd_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [255:0] line, input int gap);
    int lat;
    int resp_cnt;
    lat = 0;
    resp_cnt = 0;
    pmem_address = addr;
    pmem_read    = 1'b1;
    bmem_ready   = 1'b1;
    bmem_rvalid  = 1'b0;
    @(negedge clk); lat++;
    chk("rd_cmd", bmem_read, 1);
    chk("rd_addr", bmem_addr, exp_addr);
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); lat++;
    if (pmem_resp) resp_cnt++;
    chk("rd_cmd_drop", bmem_read, 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk); lat++;
        if (pmem_resp) resp_cnt++;
      end
      bmem_rvalid = 1'b1;
      bmem_rdata  = line[b*64 +: 64];
      @(negedge clk); lat++;
      if (b < 3 && pmem_resp) resp_cnt++;
    end
    chk("rd_resp_early", resp_cnt, 0);
    chk("rd_resp", pmem_resp, 1);
    chk("rd_latency", lat, 6 + 4 * gap);
    chk("rd_line", pmem_rdata, line);
    bmem_rvalid = 1'b0;
    pmem_read   = 1'b0;
    @(negedge clk);
    chk("rd_resp_pulse", pmem_resp, 0);
  endtask

  // Write burst with ready alternating 0,1,0,1... starting on the first beat.
  task automatic wr_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [255:0] line, input logic with_read);
    int acc;
    int n;
    acc = 0;
    n = 0;
    pmem_address = addr;
    pmem_wdata   = line;
    pmem_write   = 1'b1;
    pmem_read    = with_read;
    bmem_ready   = 1'b0;
    @(negedge clk);
    chk("wr_no_rd", bmem_read, 0);
    while (acc < 4 && n < 40) begin
      chk("wr_valid", bmem_write, 1);
      chk("wr_beat", bmem_wdata, line[acc*64 +: 64]);
      chk("wr_addr", bmem_addr, exp_addr);
      chk("wr_resp_early", pmem_resp, 0);
      bmem_ready = n[0];
      if (n[0]) acc++;
      @(negedge clk);
      n++;
    end
    chk("wr_beats", acc, 4);
    chk("wr_resp", pmem_resp, 1);
    chk("wr_done", bmem_write, 0);
    pmem_write = 1'b0;
    pmem_read  = 1'b0;
    bmem_ready = 1'b0;
    @(negedge clk);
    chk("wr_resp_pulse", pmem_resp, 0);
    chk("wr_idle", bmem_write, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wline1 = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
              64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
    wline2 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
              64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
    rline1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rline2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'hA5A5_5A5A_A5A5_5A5A};
    rline3 = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
              64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
    rline4 = {64'h1000_2000_3000_4000, 64'h5000_6000_7000_8000,
              64'h9000_A000_B000_C000, 64'hD000_E000_F000_0001};

    rst          = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    bmem_ready   = 1'b0;
    bmem_rdata   = '0;
    bmem_rvalid  = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    wr_line(32'h0000_1010, 32'h0000_1000, wline1, 1'b0);
`ifdef LINE_BURST_ADAPTER_PERF_EN
    chk("perf_wr_lines", dut.wr_lines, 1);
    chk("perf_rd_lines", dut.rd_lines, 0);
    chk("perf_stalls", dut.stall_cycles, 4);
`endif

    rd_line(32'h1234_5678, 32'h1234_5660, rline1, 0);

    // Both requests at once: the write burst goes first, rdata untouched.
    wr_line(32'h0000_2044, 32'h0000_2040, wline2, 1'b1);
    chk("prio_rdata_kept", pmem_rdata, rline1);
    rd_line(32'h0000_2044, 32'h0000_2040, rline2, 0);

    rd_line(32'h8000_003F, 32'h8000_0020, rline3, 2);

    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) @(negedge clk);
    bmem_rvalid = 1'b0;
    chk("stray_rdata", pmem_rdata, rline3);
    chk("stray_resp", pmem_resp, 0);
    chk("stray_bread", bmem_read, 0);

    // Reset after two beats of a read have landed.
    pmem_address = 32'h0000_4000;
    pmem_read    = 1'b1;
    bmem_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'h0A0A_0A0A_0A0A_0A0A;
    @(negedge clk);
    bmem_rdata  = 64'h0B0B_0B0B_0B0B_0B0B;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    pmem_read   = 1'b0;
    bmem_rvalid = 1'b0;
    @(negedge clk);
    chk("midrst_noresp", pmem_resp, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_noresp", pmem_resp, 0);
    rd_line(32'h0000_4000, 32'h0000_4000, rline4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
